// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs between the memory response
// path and the decoder. Flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          wr_en;
  logic          rd_en;
  fetch_entry_t  slot [DEPTH];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_FULL);
  assign count = count_reg;
  assign head  = slot[rd_ptr_reg];

  // A flushed cycle neither stores nor removes anything
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;

  // Storage slots are reset so the head reads as zero straight out of reset
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      fetch_entry_t entry_reg;

      // Capture the pushed pair when the write pointer lands on this slot
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign slot[gi] = entry_reg;
    end
  endgenerate

  // Pointer and occupancy update; flush empties the queue outright
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (rd_en) rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (wr_en && !rd_en) begin
        count_next = count_reg + CNT_ONE;
      end else if (!wr_en && rd_en) begin
        count_next = count_reg - CNT_ONE;
      end
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues pipelined word requests to a
// variable-latency memory, queues the returned words with their PCs and
// hands them to the decoder. Redirects flush everything older.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  logic            run_reg;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   discard_reg, discard_next;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic [CW:0]     credit_used;
  logic            gnt_fire;
  logic [XLEN-1:0] redirect_target;

  // Every in-flight request may still land in the FIFO, so queued entries
  // plus outstanding requests must never exceed its depth
  assign credit_used     = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign imem_req        = run_reg & ~redirect & (credit_used < CREDIT_MAX);
  assign imem_addr       = fetch_pc_reg;
  assign gnt_fire        = imem_req & imem_gnt;
  assign redirect_target = align_word(redirect_pc);

  // Responses are kept only when no stale ones remain ahead of them
  assign fifo_push        = imem_rvalid & (discard_reg == '0) & ~redirect;
  assign fifo_pop         = instr_ready & ~redirect;
  assign push_entry.pc    = resp_pc_reg;
  assign push_entry.instr = imem_rdata;

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // PC and in-flight bookkeeping; a redirect overrides every other event
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (redirect) begin
      fetch_pc_next    = redirect_target;
      resp_pc_next     = redirect_target;
      // No grant is possible this cycle; whatever is still in flight after
      // a same-cycle response (stale or not) belongs to the old stream
      outstanding_next = outstanding_reg - CW'(imem_rvalid);
      discard_next     = outstanding_reg - CW'(imem_rvalid);
    end else begin
      if (gnt_fire) fetch_pc_next = fetch_pc_reg + PC_STEP;
      if (gnt_fire && !imem_rvalid) begin
        outstanding_next = outstanding_reg + CNT_ONE;
      end else if (!gnt_fire && imem_rvalid) begin
        outstanding_next = outstanding_reg - CNT_ONE;
      end
      if (imem_rvalid) begin
        if (discard_reg != '0) begin
          discard_next = discard_reg - CNT_ONE;
        end else begin
          resp_pc_next = resp_pc_reg + PC_STEP;
        end
      end
    end
  end

  // Fetch state registers; run_reg holds requests off until the first edge after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_reg         <= 1'b0;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      run_reg         <= 1'b1;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  // Protocol guards: no response without a request, no push into a full queue
  always_ff @(posedge clk) begin
    if (reset && imem_rvalid) begin
      assert (outstanding_reg != '0);
    end
    if (reset && fifo_push) begin
      assert (!fifo_full);
    end
  end

endmodule
